// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-organised, byte-masked data RAM.
// Unaligned accesses crossing a word boundary are split into two aligned word transactions.
module lsu_mem_master #(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_req_addr,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic              o_mem_rden,
    output logic              o_mem_wren,
    output logic [3:0]        o_mem_bmask,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP, ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word0_q, word0_d;
    logic [31:0]       word1_q, word1_d;
    logic [1:0]        cnt_q, cnt_d;

    function automatic logic [2:0] sizeOf(input logic [1:0] f);
        case (f)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic [2:0]      reqSize;
    logic [ADDR_W:0] reqEnd;
    logic            reqFunctBad;
    logic            reqErr;

    always_comb begin
        reqSize = sizeOf(i_req_funct3[1:0]);
        reqEnd  = {1'b0, i_req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(reqSize - 3'd1);
        if (i_req_we)
            reqFunctBad = !(i_req_funct3 == 3'b000 || i_req_funct3 == 3'b001 || i_req_funct3 == 3'b010);
        else
            reqFunctBad = (i_req_funct3 == 3'b011 || i_req_funct3 == 3'b110 || i_req_funct3 == 3'b111);
        reqErr = reqFunctBad || (|i_req_addr[31:ADDR_W]) || reqEnd[ADDR_W];
    end

    logic [2:0]        curSize;
    logic [1:0]        off;
    logic              split;
    logic [3:0]        mask4;
    logic [7:0]        m8;
    logic [63:0]       d64;
    logic [ADDR_W-3:0] wordIdx;
    logic [31:0]       r32;
    logic [31:0]       loadData;

    // Lane placement of the captured request and extension of the assembled load word.
    always_comb begin
        curSize  = sizeOf(funct3_q[1:0]);
        off      = addr_q[1:0];
        split    = ({1'b0, off} + curSize) > 3'd4;
        case (curSize)
            3'd1:    mask4 = 4'b0001;
            3'd2:    mask4 = 4'b0011;
            default: mask4 = 4'b1111;
        endcase
        m8       = {4'b0000, mask4} << off;
        d64      = {32'b0, wdata_q} << {off, 3'b000};
        wordIdx  = addr_q[ADDR_W-1:2];
        r32      = 32'({word1_q, word0_q} >> {off, 3'b000});
        case (funct3_q)
            3'b000:  loadData = {{24{r32[7]}}, r32[7:0]};
            3'b001:  loadData = {{16{r32[15]}}, r32[15:0]};
            3'b100:  loadData = {24'b0, r32[7:0]};
            3'b101:  loadData = {16'b0, r32[15:0]};
            default: loadData = r32;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            word0_q  <= 32'h0;
            word1_q  <= 32'h0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            word0_q  <= word0_d;
            word1_q  <= word1_d;
            cnt_q    <= cnt_d;
        end
    end

    // Each WAIT state lasts RD_LAT cycles; the read word is captured on its last cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        word0_d     = word0_q;
        word1_d     = word1_q;
        cnt_d       = cnt_q;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = 32'h0;
        o_rsp_err   = 1'b0;
        o_mem_addr  = '0;
        o_mem_rden  = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_bmask = 4'b0000;
        o_mem_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    addr_d   = i_req_addr[ADDR_W-1:0];
                    we_d     = i_req_we;
                    funct3_d = i_req_funct3;
                    wdata_d  = i_req_wdata;
                    word0_d  = 32'h0;
                    word1_d  = 32'h0;
                    state_d  = reqErr ? ERR : ACC0;
                end
            end
            ACC0: begin
                o_mem_addr = wordIdx;
                if (we_q) begin
                    o_mem_wren  = 1'b1;
                    o_mem_bmask = m8[3:0];
                    o_mem_wdata = d64[31:0];
                    state_d     = split ? ACC1 : RESP;
                end else begin
                    o_mem_rden = 1'b1;
                    cnt_d      = 2'(RD_LAT - 1);
                    state_d    = WAIT0;
                end
            end
            WAIT0: begin
                if (cnt_q == 2'd0) begin
                    word0_d = i_mem_rdata;
                    state_d = split ? ACC1 : RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACC1: begin
                o_mem_addr = wordIdx + (ADDR_W-2)'(1);
                if (we_q) begin
                    o_mem_wren  = 1'b1;
                    o_mem_bmask = m8[7:4];
                    o_mem_wdata = d64[63:32];
                    state_d     = RESP;
                end else begin
                    o_mem_rden = 1'b1;
                    cnt_d      = 2'(RD_LAT - 1);
                    state_d    = WAIT1;
                end
            end
            WAIT1: begin
                if (cnt_q == 2'd0) begin
                    word1_d = i_mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = we_q ? 32'h0 : loadData;
                state_d     = IDLE;
            end
            ERR: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench driving identical requests into a RD_LAT=1 and a RD_LAT=3 instance,
// each backed by its own byte-masked RAM model with exact read latency.
module tb_lsu_mem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        reqWe;
    logic [2:0]  reqFunct3;
    logic [31:0] reqWdata;

    logic        ready1, rspValid1, rspErr1, rden1, wren1;
    logic [31:0] rspRdata1, memWdata1, rdata1;
    logic [8:0]  memAddr1;
    logic [3:0]  bmask1;
    logic        ready3, rspValid3, rspErr3, rden3, wren3;
    logic [31:0] rspRdata3, memWdata3, rdata3, pipe3a, pipe3b;
    logic [8:0]  memAddr3;
    logic [3:0]  bmask3;

    lsu_mem_master #(.ADDR_W(11), .RD_LAT(1)) dut1 (
        .i_clk(clk), .i_reset(rstn), .i_req_valid(reqValid), .o_req_ready(ready1),
        .i_req_addr(reqAddr), .i_req_we(reqWe), .i_req_funct3(reqFunct3), .i_req_wdata(reqWdata),
        .o_rsp_valid(rspValid1), .o_rsp_rdata(rspRdata1), .o_rsp_err(rspErr1),
        .o_mem_addr(memAddr1), .o_mem_rden(rden1), .o_mem_wren(wren1),
        .o_mem_bmask(bmask1), .o_mem_wdata(memWdata1), .i_mem_rdata(rdata1));

    lsu_mem_master #(.ADDR_W(11), .RD_LAT(3)) dut3 (
        .i_clk(clk), .i_reset(rstn), .i_req_valid(reqValid), .o_req_ready(ready3),
        .i_req_addr(reqAddr), .i_req_we(reqWe), .i_req_funct3(reqFunct3), .i_req_wdata(reqWdata),
        .o_rsp_valid(rspValid3), .o_rsp_rdata(rspRdata3), .o_rsp_err(rspErr3),
        .o_mem_addr(memAddr3), .o_mem_rden(rden3), .o_mem_wren(wren3),
        .o_mem_bmask(bmask3), .o_mem_wdata(memWdata3), .i_mem_rdata(rdata3));

    logic [31:0] mem1 [0:511];
    logic [31:0] mem3 [0:511];
    logic        loadRam;

    // Read data is only present on the exact cycle RD_LAT after the strobe, zero otherwise.
    always @(posedge clk) begin
        if (loadRam) begin
            mem1[0] <= 32'hCAFEF00D; mem3[0] <= 32'hCAFEF00D;
            mem1[1] <= 32'h0;        mem3[1] <= 32'h0;
            mem1[2] <= 32'h0;        mem3[2] <= 32'h0;
            mem1[3] <= 32'hA5A55A5A; mem3[3] <= 32'hA5A55A5A;
            mem1[4] <= 32'hDEADBEEF; mem3[4] <= 32'hDEADBEEF;
            mem1[511] <= 32'h1234ABCD; mem3[511] <= 32'h1234ABCD;
            rdata1 <= 32'h0; pipe3a <= 32'h0; pipe3b <= 32'h0; rdata3 <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wren1 && bmask1[b]) mem1[memAddr1][8*b +: 8] <= memWdata1[8*b +: 8];
                if (wren3 && bmask3[b]) mem3[memAddr3][8*b +: 8] <= memWdata3[8*b +: 8];
            end
            rdata1 <= rden1 ? mem1[memAddr1] : 32'h0;
            pipe3a <= rden3 ? mem3[memAddr3] : 32'h0;
            pipe3b <= pipe3a;
            rdata3 <= pipe3b;
        end
    end

    int checks = 0;
    int passes = 0;

    int          rspCyc [2];
    int          rspCnt [2];
    int          strobeCnt [2];
    int          junk [2];
    logic        readyAt1 [2];
    logic [31:0] rspData [2];
    logic        rspErrQ [2];
    int          stCyc [2][2];
    logic [8:0]  stIdx [2][2];
    logic [3:0]  stMask [2][2];
    logic [31:0] stWd [2][2];
    logic        stWr [2][2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic outsNonZero(input int k);
        if (k == 0)
            return rspValid1 | rspErr1 | (|rspRdata1) | (|memAddr1) | rden1 | wren1 | (|bmask1) | (|memWdata1);
        else
            return rspValid3 | rspErr3 | (|rspRdata3) | (|memAddr3) | rden3 | wren3 | (|bmask3) | (|memWdata3);
    endfunction

    task automatic clearLog();
        for (int k = 0; k < 2; k++) begin
            rspCyc[k] = 0; rspCnt[k] = 0; strobeCnt[k] = 0; junk[k] = 0;
            readyAt1[k] = 1'b0; rspData[k] = 32'h0; rspErrQ[k] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                stCyc[k][i] = 0; stIdx[k][i] = '0; stMask[k][i] = '0; stWd[k][i] = '0; stWr[k][i] = 1'b0;
            end
        end
    endtask

    task automatic sampleDut(input int k, input int n);
        logic rv, re, rd, wr, rdy;
        logic [31:0] rdat, wd;
        logic [3:0] bm;
        logic [8:0] ad;
        if (k == 0) begin
            rv = rspValid1; re = rspErr1; rd = rden1; wr = wren1; rdy = ready1;
            rdat = rspRdata1; wd = memWdata1; bm = bmask1; ad = memAddr1;
        end else begin
            rv = rspValid3; re = rspErr3; rd = rden3; wr = wren3; rdy = ready3;
            rdat = rspRdata3; wd = memWdata3; bm = bmask3; ad = memAddr3;
        end
        if (n == 1) readyAt1[k] = rdy;
        if (rv) begin
            rspCnt[k]++;
            if (rspCyc[k] == 0) rspCyc[k] = n;
            rspData[k] = rdat;
            rspErrQ[k] = re;
        end else if (re || rdat != 32'h0) begin
            junk[k]++;
        end
        if (rd || wr) begin
            if (strobeCnt[k] < 2) begin
                stCyc[k][strobeCnt[k]]  = n;
                stIdx[k][strobeCnt[k]]  = ad;
                stMask[k][strobeCnt[k]] = bm;
                stWd[k][strobeCnt[k]]   = wd;
                stWr[k][strobeCnt[k]]   = wr;
            end
            strobeCnt[k]++;
            if (rd && wr) junk[k]++;
        end else if (ad != '0 || bm != '0 || wd != '0) begin
            junk[k]++;
        end
    endtask

    task automatic runCycles(input int count);
        for (int n = 1; n <= count; n++) begin
            sampleDut(0, n);
            sampleDut(1, n);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int expLat(input logic we, input logic split, input logic err, input int lat);
        if (err) return 1;
        if (we) return split ? 3 : 2;
        return split ? 3 + 2 * lat : 2 + lat;
    endfunction

    task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic expErr, input logic expSplit, input logic [31:0] expData,
                                 input logic [8:0] idx0, input logic [3:0] m0, input logic [31:0] w0,
                                 input logic [3:0] m1, input logic [31:0] w1);
        @(negedge clk);
        checkOutput({name, "/idleReady1"}, {31'b0, ready1}, 32'd1);
        checkOutput({name, "/idleReady3"}, {31'b0, ready3}, 32'd1);
        reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = addr; reqWdata = wdata;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        clearLog();
        runCycles(16);
        for (int k = 0; k < 2; k++) begin
            int lat;
            string p;
            lat = (k == 0) ? 1 : 3;
            p = $sformatf("%s/L%0d", name, lat);
            checkOutput({p, "/busyReady"}, {31'b0, readyAt1[k]}, 32'd0);
            checkOutput({p, "/rspCycle"}, rspCyc[k], expLat(we, expSplit, expErr, lat));
            checkOutput({p, "/rspCount"}, rspCnt[k], 32'd1);
            checkOutput({p, "/rspErr"}, {31'b0, rspErrQ[k]}, {31'b0, expErr});
            checkOutput({p, "/rdata"}, rspData[k], expData);
            checkOutput({p, "/stray"}, junk[k], 32'd0);
            checkOutput({p, "/strobes"}, strobeCnt[k], expErr ? 0 : (expSplit ? 2 : 1));
            if (!expErr) begin
                checkOutput({p, "/s0cyc"}, stCyc[k][0], 32'd1);
                checkOutput({p, "/s0idx"}, {23'b0, stIdx[k][0]}, {23'b0, idx0});
                checkOutput({p, "/s0mask"}, {28'b0, stMask[k][0]}, {28'b0, m0});
                checkOutput({p, "/s0wdata"}, stWd[k][0], w0);
                checkOutput({p, "/s0we"}, {31'b0, stWr[k][0]}, {31'b0, we});
            end
            if (expSplit && !expErr) begin
                checkOutput({p, "/s1cyc"}, stCyc[k][1], we ? 2 : 2 + lat);
                checkOutput({p, "/s1idx"}, {23'b0, stIdx[k][1]}, {23'b0, idx0 + 9'd1});
                checkOutput({p, "/s1mask"}, {28'b0, stMask[k][1]}, {28'b0, m1});
                checkOutput({p, "/s1wdata"}, stWd[k][1], w1);
                checkOutput({p, "/s1we"}, {31'b0, stWr[k][1]}, {31'b0, we});
            end
        end
    endtask

    task automatic resetMidLoad();
        @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b0; reqFunct3 = 3'b010; reqAddr = 32'h00E; reqWdata = 32'h0;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        clearLog();
        runCycles(1);
        rstn = 1'b0;
        #1;
        checkOutput("midReset/outs1", {31'b0, outsNonZero(0)}, 32'd0);
        checkOutput("midReset/outs3", {31'b0, outsNonZero(1)}, 32'd0);
        checkOutput("midReset/ready1", {31'b0, ready1}, 32'd1);
        checkOutput("midReset/ready3", {31'b0, ready3}, 32'd1);
        clearLog();
        runCycles(3);
        @(negedge clk);
        rstn = 1'b1;
        runCycles(10);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("midReset/rsp%0d", k), rspCnt[k], 32'd0);
            checkOutput($sformatf("midReset/strobes%0d", k), strobeCnt[k], 32'd0);
        end
    endtask

    initial begin
        rstn = 1'b0; reqValid = 1'b0; reqAddr = 32'h0; reqWe = 1'b0; reqFunct3 = 3'b000; reqWdata = 32'h0;
        loadRam = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        loadRam = 1'b0;
        checkOutput("reset/outs1", {31'b0, outsNonZero(0)}, 32'd0);
        checkOutput("reset/outs3", {31'b0, outsNonZero(1)}, 32'd0);
        checkOutput("reset/ready1", {31'b0, ready1}, 32'd1);
        checkOutput("reset/ready3", {31'b0, ready3}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        //            name        we  f3      addr       wdata         err   split expData        idx  m0       w0            m1       w1
        applyStimulus("lw010",    0, 3'b010, 32'h010, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 9'd4, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("lw00e",    0, 3'b010, 32'h00E, 32'h0,        1'b0, 1'b1, 32'hBEEFA5A5, 9'd3, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("sb013",    1, 3'b000, 32'h013, 32'h12345680, 1'b0, 1'b0, 32'h0,        9'd4, 4'b1000, 32'h80000000, 4'b0000, 32'h0);
        applyStimulus("lb013",    0, 3'b000, 32'h013, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80, 9'd4, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("lbu013",   0, 3'b100, 32'h013, 32'h0,        1'b0, 1'b0, 32'h00000080, 9'd4, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("sh012",    1, 3'b001, 32'h012, 32'h00008001, 1'b0, 1'b0, 32'h0,        9'd4, 4'b1100, 32'h80010000, 4'b0000, 32'h0);
        applyStimulus("lh012",    0, 3'b001, 32'h012, 32'h0,        1'b0, 1'b0, 32'hFFFF8001, 9'd4, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("lh001",    0, 3'b001, 32'h001, 32'h0,        1'b0, 1'b0, 32'hFFFFFEF0, 9'd0, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("sw006",    1, 3'b010, 32'h006, 32'h11223344, 1'b0, 1'b1, 32'h0,        9'd1, 4'b1100, 32'h33440000, 4'b0011, 32'h00001122);
        applyStimulus("lw006",    0, 3'b010, 32'h006, 32'h0,        1'b0, 1'b1, 32'h11223344, 9'd1, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("lh003",    0, 3'b001, 32'h003, 32'h0,        1'b0, 1'b1, 32'h000000CA, 9'd0, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("lhu7fe",   0, 3'b101, 32'h7FE, 32'h0,        1'b0, 1'b0, 32'h00001234, 9'd511, 4'b0000, 32'h0,      4'b0000, 32'h0);
        applyStimulus("lh7ff",    0, 3'b001, 32'h7FF, 32'h0,        1'b1, 1'b0, 32'h0,        9'd0, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("ld011",    0, 3'b011, 32'h000, 32'h0,        1'b1, 1'b0, 32'h0,        9'd0, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("st100",    1, 3'b100, 32'h000, 32'h55555555, 1'b1, 1'b0, 32'h0,        9'd0, 4'b0000, 32'h0,        4'b0000, 32'h0);
        applyStimulus("lw800",    0, 3'b010, 32'h800, 32'h0,        1'b1, 1'b0, 32'h0,        9'd0, 4'b0000, 32'h0,        4'b0000, 32'h0);

        resetMidLoad();
        applyStimulus("lwAfterRst", 0, 3'b010, 32'h000, 32'h0,      1'b0, 1'b0, 32'hCAFEF00D, 9'd0, 4'b0000, 32'h0,        4'b0000, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
